// File: rtl/i2c_eeprom_target_if.sv
// i2c_eeprom_target_if: status and write-commit signals of the EEPROM target
interface i2c_eeprom_target_if #(
  parameter int ADDR_W = 9
);
  logic busy;
  logic wr_strobe;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0] wr_data;
  modport slave (output busy, wr_strobe, wr_addr, wr_data);
  modport master (input busy, wr_strobe, wr_addr, wr_data);
endinterface

// File: rtl/i2c_eeprom_target.sv
// i2c_eeprom_target: 24Cxx-style 512-byte I2C EEPROM responder with page-wrapped writes
module i2c_eeprom_target #(
  parameter logic [5:0] DEV_ADDR = 6'b101000,
  parameter int MEM_DEPTH = 512,
  parameter int ADDR_W = 9,
  parameter int PAGE = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  input logic scl,
  inout wire sda,
  i2c_eeprom_target_if.slave st
);
  localparam int PB = $clog2(PAGE);
  typedef enum logic [3:0] {
    IDLE, DEVADDR, DEV_ACK, WORDADDR, WA_ACK, WRITE, WR_ACK, READ, RD_ACK, IGNORE
  } state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] scl_s, sda_s;
  logic scl_r, sda_r, scl_d, sda_d;
  logic rise, fall, start, stop;
  logic [7:0] sr, rx, rd;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] ptr;
  logic p0, rw, sda_low;
  logic [7:0] mem [MEM_DEPTH] = '{default: 8'h00};
  assign scl_r = scl_s[SYNC_STAGES-1];
  assign sda_r = sda_s[SYNC_STAGES-1];
  assign rise = scl_r & ~scl_d;
  assign fall = ~scl_r & scl_d;
  assign start = scl_r & scl_d & sda_d & ~sda_r;
  assign stop = scl_r & scl_d & ~sda_d & sda_r;
  assign rx = {sr[6:0], sda_r};
  assign rd = mem[ptr];
  assign sda = sda_low ? 1'b0 : 1'bz;
  // Drive changes are registered on the fall, so SDA only moves while SCL is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s <= '1;
      sda_s <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      ptr <= '0;
      p0 <= 1'b0;
      rw <= 1'b0;
      sda_low <= 1'b0;
      st.busy <= 1'b0;
      st.wr_strobe <= 1'b0;
      st.wr_addr <= '0;
      st.wr_data <= '0;
    end else begin
      scl_s <= {scl_s[SYNC_STAGES-2:0], scl};
      sda_s <= {sda_s[SYNC_STAGES-2:0], sda};
      scl_d <= scl_r;
      sda_d <= sda_r;
      st.wr_strobe <= 1'b0;
      if (start || stop) begin
        state <= start ? DEVADDR : IDLE;
        st.busy <= start;
        cnt <= '0;
        sda_low <= 1'b0;
      end else if (rise) begin
        case (state)
          DEVADDR: begin
            sr <= rx;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt <= '0;
              state <= (rx[7:2] == DEV_ADDR) ? DEV_ACK : IGNORE;
              p0 <= rx[1];
              rw <= rx[0];
            end
          end
          WORDADDR: begin
            sr <= rx;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt <= '0;
              ptr <= {p0, rx};
              state <= WA_ACK;
            end
          end
          WRITE: begin
            sr <= rx;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt <= '0;
              st.wr_strobe <= 1'b1;
              st.wr_addr <= ptr;
              st.wr_data <= rx;
              ptr <= {ptr[ADDR_W-1:PB], ptr[PB-1:0] + PB'(1)};
              state <= WR_ACK;
            end
          end
          READ: begin
            sr <= rx;
            cnt <= cnt + 4'd1;
          end
          RD_ACK: begin
            if (sda_r) state <= IGNORE;
            else cnt <= 4'd1;
          end
          default: ;
        endcase
      end else if (fall) begin
        case (state)
          DEV_ACK, WA_ACK, WR_ACK: begin
            if (cnt == 4'd0) begin
              sda_low <= 1'b1;
              cnt <= 4'd1;
            end else if (state == DEV_ACK && rw) begin
              sr <= rd;
              sda_low <= ~rd[7];
              cnt <= '0;
              state <= READ;
            end else begin
              sda_low <= 1'b0;
              cnt <= '0;
              state <= (state == DEV_ACK) ? WORDADDR : WRITE;
            end
          end
          READ: begin
            if (cnt == 4'd8) begin
              sda_low <= 1'b0;
              cnt <= '0;
              ptr <= ptr + ADDR_W'(1);
              state <= RD_ACK;
            end else begin
              sda_low <= ~sr[7];
            end
          end
          RD_ACK: begin
            if (cnt == 4'd1) begin
              sr <= rd;
              sda_low <= ~rd[7];
              cnt <= '0;
              state <= READ;
            end
          end
          default: ;
        endcase
      end
    end
  end
  always_ff @(posedge clk) begin
    if (st.wr_strobe) mem[st.wr_addr] <= st.wr_data;
  end
endmodule
